// File: rtl/mem_stage_sram_ctrl.sv
// Splits MEM-stage 32-bit loads/stores into two 16-bit SRAM half-word accesses held LAT cycles each.
// Latency: 2*LAT+2 cycles from request to DONE; ready is low for 2*LAT+1 of them, which freezes the pipeline.
module mem_stage_sram_ctrl #(
    parameter int unsigned ADDR_BASE = 1024,
    parameter int          SRAM_AW   = 18,
    parameter int          LAT       = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               memREn,
    input  logic               memWEn,
    input  logic [31:0]        addr,
    input  logic [31:0]        wrData,
    output logic [31:0]        rdData,
    output logic               ready,
    output logic [SRAM_AW-1:0] sramAddr,
    output logic [15:0]        sramDqOut,
    output logic               sramDqOe,
    input  logic [15:0]        sramDqIn,
    output logic               sramWeN
);

    typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

    localparam logic [3:0] CNT_LAST = 4'(LAT - 1);

    state_t             state;
    logic [3:0]         cnt;
    logic [SRAM_AW-2:0] wordAddr;
    logic [31:0]        wrBuf;
    logic               isWr;
    logic [31:0]        offset;
    logic               req;
    logic               unusedOffsetBits;

    // Wraps modulo 2^32 for addresses below ADDR_BASE; the low two bits are dropped (word access only).
    assign offset           = addr - 32'(ADDR_BASE);
    assign unusedOffsetBits = ^{offset[31:SRAM_AW+1], offset[1:0]};
    assign req              = memREn | memWEn;
    assign ready            = (state == DONE) || ((state == IDLE) && !req);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            wordAddr  <= '0;
            wrBuf     <= 32'd0;
            isWr      <= 1'b0;
            rdData    <= 32'd0;
            sramAddr  <= '0;
            sramDqOut <= 16'd0;
            sramDqOe  <= 1'b0;
            sramWeN   <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (req) begin
                        // A simultaneous load+store request is performed as a store.
                        wordAddr  <= offset[SRAM_AW:2];
                        wrBuf     <= wrData;
                        isWr      <= memWEn;
                        cnt       <= 4'd0;
                        sramAddr  <= {offset[SRAM_AW:2], 1'b0};
                        sramDqOut <= wrData[15:0];
                        sramDqOe  <= memWEn;
                        sramWeN   <= ~memWEn;
                        state     <= LO;
                    end
                end
                LO: begin
                    if (cnt == CNT_LAST) begin
                        if (!isWr) begin
                            rdData[15:0] <= sramDqIn;
                        end
                        cnt       <= 4'd0;
                        sramAddr  <= {wordAddr, 1'b1};
                        sramDqOut <= wrBuf[31:16];
                        state     <= HI;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                HI: begin
                    if (cnt == CNT_LAST) begin
                        if (!isWr) begin
                            rdData[31:16] <= sramDqIn;
                        end
                        cnt      <= 4'd0;
                        sramWeN  <= 1'b1;
                        sramDqOe <= 1'b0;
                        state    <= DONE;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                DONE: begin
                    // A request still present here is the one just completed; never restart it.
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/mem_stage_sram_ctrl.md
Name: mem_stage_sram_ctrl

Overview:
Sequences the MEM stage's 32-bit loads and stores onto a 16-bit-wide external SRAM. Each access is split into two half-word accesses (low half, then high half), each held for a programmable number of cycles. While an access is in flight, the controller deasserts ready, and the pipeline freezes all stages so the EX/MEM outputs stay stable. The block sits between the EX/MEM pipeline register (aluRes address, exeValRm store data, memREn/memWEn) and the SRAM pins; its read data feeds the MEM/WB register.

Parameters:
ADDR_BASE, 1024, byte address mapped to SRAM word 0; subtracted from the incoming address.
SRAM_AW, 18, SRAM half-word address width.
LAT, 2, cycles each half-word access is held (legal range 1..15).

Ports:
clk  in  1  clock, all state updates on rising edge.
rst  in  1  asynchronous active-low reset.
memREn  in  1  load request from EX/MEM, held stable while ready=0.
memWEn  in  1  store request from EX/MEM, held stable while ready=0.
addr  in  32  byte address (ALU result).
wrData  in  32  store data.
rdData  out  32  load result, valid while ready=1 in DONE.
ready  out  1  0 = freeze pipeline.
sramAddr  out  SRAM_AW  half-word address.
sramDqOut  out  16  write data driven to SRAM.
sramDqOe  out  1  1 = drive sramDqOut onto the bus.
sramDqIn  in  16  read data from SRAM.
sramWeN  out  1  active-low write enable.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, counter=0, rdData=0, sramAddr=0, sramDqOut=0, sramDqOe=0, sramWeN=1. Reset mid-access aborts the access immediately, with no partial write completion guaranteed.
- FSM states: IDLE, LO, HI, DONE.
- IDLE:
  - If memREn|memWEn is high: latch wordAddr=(addr-ADDR_BASE)[SRAM_AW:2], latch wrData and op (write if memWEn, else read), clear counter, go to LO.
  - If both memREn and memWEn are high: treat as a write.
  - addr[1:0] is ignored (word-aligned only).
- LO:
  - sramAddr={wordAddr,0}, sramDqOut=wrData[15:0].
  - Write: sramDqOe=1, sramWeN=0. Read: sramDqOe=0, sramWeN=1.
  - Counter increments each cycle. On the cycle where counter==LAT-1, a read captures sramDqIn into rdData[15:0]; then counter clears and the FSM goes to HI.
- HI: same as LO, with sramAddr={wordAddr,1}, wrData[31:16], and capture into rdData[31:16]; then go to DONE.
- DONE: one cycle, sramWeN=1, sramDqOe=0. Unconditionally return to IDLE; a request still visible in DONE is the current one and is not restarted.
- ready (combinational): 1 in DONE, or in IDLE with no request; 0 otherwise, including the IDLE cycle in which a request is first seen.
- Latency: the request first appears in cycle 0. ready is low in cycles 0..2*LAT and high in cycle 2*LAT+1 (DONE), so there are 2*LAT+1 freeze cycles per access.
- Stores leave rdData unchanged.
- sramWeN is never low outside LO/HI. sramAddr and sramDqOut are stable for the whole of each phase.
- Address arithmetic is modulo 2^32; results below ADDR_BASE wrap and are not flagged.
- Requests changing while ready=0 is a pipeline error; the latched values are used.

Test Plan:
- Reset with rst=0 mid-HI of a store -> same cycle: sramWeN=1, sramDqOe=0, rdData=0, ready=1 once rst=1 with no request.
- Store, LAT=2, addr=1032, wrData=0xDEADBEEF:
  - ready=0 in cycles 0-4.
  - sramAddr=4, sramDqOut=0xBEEF, sramWeN=0 in cycles 1-2.
  - sramAddr=5, sramDqOut=0xDEAD, sramWeN=0 in cycles 3-4.
  - ready=1 in cycle 5.
- Load, addr=1032, SRAM model returning 0xBEEF at 4 and 0xDEAD at 5 -> sramWeN stays 1, rdData=0xDEADBEEF with ready=1 in cycle 5.
- Back-to-back load then store (pipeline advances at DONE) -> IDLE gap cycle with ready=0, second access sramAddr sequence correct, no extra DONE.
- memREn=memWEn=1, LAT=1, addr=1024 -> write performed at sramAddr 0 and 1, ready=1 in cycle 3.
- No request for 10 cycles -> ready=1 throughout, sramWeN=1, sramDqOe=0.
